// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of the load/store unit: issues one access at a
// time, routes the load response to its owner and times out unanswered loads.
module lsu_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int          RD_TIMEOUT = 4,
    parameter logic [31:0] IDLE_ADDR  = 32'hFFFF_FFF0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_strb,
    input  logic        i_m0_wren,
    output logic        o_m0_gnt,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_rvld,
    output logic        o_m0_err,

    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_strb,
    input  logic        i_m1_wren,
    output logic        o_m1_gnt,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_rvld,
    output logic        o_m1_err,

    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data,
    input  logic        i_data_vld
);

    localparam int               CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last;
    logic             owner;
    logic             pick_m1;

    // On a tie, round-robin hands the bus to whoever did not own it last.
    assign pick_m1 = i_m1_req && (!i_m0_req || (!FIXED_PRIO && !last));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last       <= 1'b1;
            owner      <= 1'b0;
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_rvld  <= 1'b0;
            o_m1_rvld  <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m0_rdata <= '0;
            o_m1_rdata <= '0;
            o_lsu_addr <= IDLE_ADDR;
            o_st_data  <= '0;
            o_st_strb  <= '0;
            o_lsu_wren <= 1'b0;
        end else begin
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_rvld  <= 1'b0;
            o_m1_rvld  <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_err   <= 1'b0;
            // The bus is parked unless a grant is being issued this cycle.
            o_lsu_addr <= IDLE_ADDR;
            o_st_data  <= '0;
            o_st_strb  <= '0;
            o_lsu_wren <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        owner      <= pick_m1;
                        last       <= pick_m1;
                        o_m0_gnt   <= !pick_m1;
                        o_m1_gnt   <= pick_m1;
                        o_lsu_addr <= pick_m1 ? i_m1_addr  : i_m0_addr;
                        o_st_data  <= pick_m1 ? i_m1_wdata : i_m0_wdata;
                        o_st_strb  <= pick_m1 ? i_m1_strb  : i_m0_strb;
                        o_lsu_wren <= pick_m1 ? i_m1_wren  : i_m0_wren;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= o_lsu_wren ? IDLE : WAIT;
                end

                WAIT: begin
                    if (i_data_vld) begin
                        if (owner) begin
                            o_m1_rdata <= i_ld_data;
                            o_m1_rvld  <= 1'b1;
                        end else begin
                            o_m0_rdata <= i_ld_data;
                            o_m0_rvld  <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        if (owner) begin
                            o_m1_rdata <= '0;
                            o_m1_rvld  <= 1'b1;
                            o_m1_err   <= 1'b1;
                        end else begin
                            o_m0_rdata <= '0;
                            o_m0_rvld  <= 1'b1;
                            o_m0_err   <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a small RAM/MMIO responder standing in for the LSU.
module tb_lsu_arbiter;

    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wren, m1_req, m1_wren;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        m0_gnt, m0_rvld, m0_err, m1_gnt, m1_rvld, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] lsu_addr, st_data, ld_data;
    logic [3:0]  st_strb;
    logic        lsu_wren, data_vld;

    logic        fp_m0_gnt, fp_m0_rvld, fp_m0_err, fp_m1_gnt, fp_m1_rvld, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_lsu_addr, fp_st_data;
    logic [3:0]  fp_st_strb;
    logic        fp_lsu_wren;

    logic        auto_lsu, inject_vld, model_vld;
    logic [31:0] inject_data, model_data, io_sw, merged;
    logic [31:0] ram [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_strb(m0_strb), .i_m0_wren(m0_wren),
        .o_m0_gnt(m0_gnt), .o_m0_rdata(m0_rdata), .o_m0_rvld(m0_rvld), .o_m0_err(m0_err),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_strb(m1_strb), .i_m1_wren(m1_wren),
        .o_m1_gnt(m1_gnt), .o_m1_rdata(m1_rdata), .o_m1_rvld(m1_rvld), .o_m1_err(m1_err),
        .o_lsu_addr(lsu_addr), .o_st_data(st_data), .o_st_strb(st_strb),
        .o_lsu_wren(lsu_wren), .i_ld_data(ld_data), .i_data_vld(data_vld)
    );

    lsu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_strb(m0_strb), .i_m0_wren(m0_wren),
        .o_m0_gnt(fp_m0_gnt), .o_m0_rdata(fp_m0_rdata), .o_m0_rvld(fp_m0_rvld), .o_m0_err(fp_m0_err),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_strb(m1_strb), .i_m1_wren(m1_wren),
        .o_m1_gnt(fp_m1_gnt), .o_m1_rdata(fp_m1_rdata), .o_m1_rvld(fp_m1_rvld), .o_m1_err(fp_m1_err),
        .o_lsu_addr(fp_lsu_addr), .o_st_data(fp_st_data), .o_st_strb(fp_st_strb),
        .o_lsu_wren(fp_lsu_wren), .i_ld_data(ld_data), .i_data_vld(data_vld)
    );

    // LSU stand-in: RAM at 0x0000-0x3FFF, switch register at 0x7800, one-cycle registered response.
    assign data_vld = model_vld | inject_vld;
    assign ld_data  = inject_vld ? inject_data : model_data;

    always_comb begin
        merged = ram[lsu_addr[13:2]];
        for (int b = 0; b < 4; b++)
            if (st_strb[b]) merged[8*b +: 8] = st_data[8*b +: 8];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_vld  <= 1'b0;
            model_data <= '0;
        end else begin
            model_vld <= 1'b0;
            if (auto_lsu && lsu_addr != IDLE_ADDR) begin
                if (lsu_wren) begin
                    if (lsu_addr < 32'h4000) ram[lsu_addr[13:2]] <= merged;
                end else if (lsu_addr < 32'h4000) begin
                    model_vld  <= 1'b1;
                    model_data <= ram[lsu_addr[13:2]];
                end else if (lsu_addr == 32'h7800) begin
                    model_vld  <= 1'b1;
                    model_data <= io_sw;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic req, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb, input logic wren);
        if (m == 0) begin
            m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_strb = strb; m0_wren = wren;
        end else begin
            m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_strb = strb; m1_wren = wren;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rr_m1;
        rr_m1 = 4'b1010;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        rst_n = 1'b1; auto_lsu = 1'b1; inject_vld = 1'b0; inject_data = '0;
        io_sw = 32'hDEAD_0001;
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_addr",  lsu_addr, IDLE_ADDR);
        checkOutput("rst_wren",  {31'b0, lsu_wren}, 32'h0);
        checkOutput("rst_strb",  {28'b0, st_strb}, 32'h0);
        checkOutput("rst_gnt",   {30'b0, m0_gnt, m1_gnt}, 32'h0);
        checkOutput("rst_rvld",  {30'b0, m0_rvld, m1_rvld}, 32'h0);
        checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // m0 store, then read it back
        applyStimulus(0, 1'b1, 32'h2004, 32'hA5A5_1234, 4'b0011, 1'b1);
        checkOutput("st_c0_addr", lsu_addr, IDLE_ADDR);
        step(1);
        checkOutput("st_m0_gnt", {31'b0, m0_gnt}, 32'h1);
        checkOutput("st_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        checkOutput("st_addr",   lsu_addr, 32'h2004);
        checkOutput("st_data",   st_data, 32'hA5A5_1234);
        checkOutput("st_strb",   {28'b0, st_strb}, 32'h3);
        checkOutput("st_wren",   {31'b0, lsu_wren}, 32'h1);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        step(1);
        checkOutput("st_c2_addr", lsu_addr, IDLE_ADDR);
        checkOutput("st_c2_wren", {31'b0, lsu_wren}, 32'h0);
        checkOutput("st_c2_gnt",  {31'b0, m0_gnt}, 32'h0);

        applyStimulus(0, 1'b1, 32'h2004, '0, '0, 1'b0);
        step(1);
        checkOutput("ld0_gnt",  {31'b0, m0_gnt}, 32'h1);
        checkOutput("ld0_addr", lsu_addr, 32'h2004);
        checkOutput("ld0_wren", {31'b0, lsu_wren}, 32'h0);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        step(1);
        checkOutput("ld0_c2_rvld", {31'b0, m0_rvld}, 32'h0);
        step(1);
        checkOutput("ld0_rvld",  {31'b0, m0_rvld}, 32'h1);
        checkOutput("ld0_rdata", m0_rdata, 32'h0000_1234);
        checkOutput("ld0_err",   {31'b0, m0_err}, 32'h0);
        step(1);
        checkOutput("ld0_pulse", {31'b0, m0_rvld}, 32'h0);

        // m1 load from the switch register
        applyStimulus(1, 1'b1, 32'h7800, '0, '0, 1'b0);
        step(1);
        checkOutput("ld1_gnt",    {31'b0, m1_gnt}, 32'h1);
        checkOutput("ld1_m0_gnt", {31'b0, m0_gnt}, 32'h0);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(2);
        checkOutput("ld1_rvld",    {31'b0, m1_rvld}, 32'h1);
        checkOutput("ld1_rdata",   m1_rdata, 32'hDEAD_0001);
        checkOutput("ld1_err",     {31'b0, m1_err}, 32'h0);
        checkOutput("ld1_m0_rvld", {30'b0, m0_rvld, m0_err}, 32'h0);
        step(1);
        checkOutput("ld1_pulse", {31'b0, m1_rvld}, 32'h0);

        // Both masters store continuously
        applyStimulus(0, 1'b1, 32'h0100, 32'h1111_1111, 4'hF, 1'b1);
        applyStimulus(1, 1'b1, 32'h0200, 32'h2222_2222, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            checkOutput("rr_gnt", {30'b0, m1_gnt, m0_gnt}, rr_m1[k] ? 32'h2 : 32'h1);
            checkOutput("fp_gnt", {30'b0, fp_m1_gnt, fp_m0_gnt}, 32'h1);
            if (k == 3) applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
            step(1);
            checkOutput("rr_gap", {30'b0, m1_gnt, m0_gnt}, 32'h0);
        end
        step(1);
        checkOutput("rr_m1_only", {30'b0, m1_gnt, m0_gnt}, 32'h2);
        checkOutput("fp_m1_only", {30'b0, fp_m1_gnt, fp_m0_gnt}, 32'h2);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(1);

        // Load timeout with m1 waiting behind it
        applyStimulus(0, 1'b1, 32'h0001_0000, '0, '0, 1'b0);
        step(1);
        checkOutput("to_gnt", {31'b0, m0_gnt}, 32'h1);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1, 1'b1, 32'h0300, 32'h3333_3333, 4'hF, 1'b1);
        step(4);
        checkOutput("to_c5_rvld", {30'b0, m0_rvld, m1_gnt}, 32'h0);
        step(1);
        checkOutput("to_rvld",   {31'b0, m0_rvld}, 32'h1);
        checkOutput("to_err",    {31'b0, m0_err}, 32'h1);
        checkOutput("to_rdata",  m0_rdata, 32'h0);
        checkOutput("to_c6_gnt", {31'b0, m1_gnt}, 32'h0);
        step(1);
        checkOutput("to_m1_gnt", {31'b0, m1_gnt}, 32'h1);
        checkOutput("to_m1_addr", lsu_addr, 32'h0300);
        checkOutput("to_pulse",  {30'b0, m0_rvld, m0_err}, 32'h0);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(1);

        // Stale response while idle
        auto_lsu = 1'b0;
        inject_vld = 1'b1; inject_data = 32'h55AA_55AA;
        step(1);
        inject_vld = 1'b0;
        checkOutput("stale_rvld", {30'b0, m0_rvld, m1_rvld}, 32'h0);
        step(1);
        checkOutput("stale_rvld2",   {30'b0, m0_rvld, m1_rvld}, 32'h0);
        checkOutput("stale_m0rdata", m0_rdata, 32'h0);
        checkOutput("stale_m1rdata", m1_rdata, 32'hDEAD_0001);

        // Reset during ISSUE of an m0 store (last owner = m0)
        applyStimulus(0, 1'b1, 32'h2008, 32'h1234_5678, 4'hF, 1'b1);
        step(1);
        checkOutput("ri_gnt_pre", {31'b0, m0_gnt}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ri_gnt",   {31'b0, m0_gnt}, 32'h0);
        checkOutput("ri_addr",  lsu_addr, IDLE_ADDR);
        checkOutput("ri_wren",  {31'b0, lsu_wren}, 32'h0);
        checkOutput("ri_rdata", m1_rdata, 32'h0);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        #2 rst_n = 1'b1;
        step(1);
        applyStimulus(0, 1'b1, 32'h0010, 32'hAAAA_0000, 4'hF, 1'b1);
        applyStimulus(1, 1'b1, 32'h0014, 32'hBBBB_0000, 4'hF, 1'b1);
        step(1);
        checkOutput("ri_tie", {30'b0, m1_gnt, m0_gnt}, 32'h1);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        step(2);
        checkOutput("ri_tie_m1", {30'b0, m1_gnt, m0_gnt}, 32'h2);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(1);

        // Reset during WAIT of an m1 load, then a late response
        applyStimulus(1, 1'b1, 32'h2000, '0, '0, 1'b0);
        step(1);
        checkOutput("rw_gnt_pre", {31'b0, m1_gnt}, 32'h1);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(1);
        rst_n = 1'b0;
        #1;
        checkOutput("rw_outs", {28'b0, m1_gnt, m1_rvld, m1_err, lsu_wren}, 32'h0);
        checkOutput("rw_addr", lsu_addr, IDLE_ADDR);
        #2 rst_n = 1'b1;
        step(1);
        inject_vld = 1'b1; inject_data = 32'hBADB_AD00;
        step(1);
        inject_vld = 1'b0;
        checkOutput("rw_late_rvld", {30'b0, m0_rvld, m1_rvld}, 32'h0);
        checkOutput("rw_late_data", m1_rdata, 32'h0);
        step(1);
        checkOutput("rw_late_rvld2", {30'b0, m0_rvld, m1_rvld}, 32'h0);
        applyStimulus(0, 1'b1, 32'h0020, 32'hCCCC_0000, 4'hF, 1'b1);
        applyStimulus(1, 1'b1, 32'h0024, 32'hDDDD_0000, 4'hF, 1'b1);
        step(1);
        checkOutput("rw_tie", {30'b0, m1_gnt, m0_gnt}, 32'h1);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-master arbiter that shares the single load/store unit port (data RAM plus MMIO) between the CPU data path (master 0) and a secondary bus master such as a debug loader or DMA engine (master 1). It sits directly in front of the LSU: it selects one request at a time, drives the LSU address, data, strobe and write-enable lines for exactly one cycle, and routes the registered load response back to the owning master. Reads that receive no LSU response within a bounded window are terminated with an error.

## Interface
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 means master 0 always wins.
- RD_TIMEOUT, 4: number of WAIT cycles without `i_data_vld` before a read is terminated with an error (≥1).
- IDLE_ADDR, 32'hFFFF_FFF0: address driven to the LSU when no access is issued. It maps to no LSU region.
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_mN_req  in  1  (N = 0, 1) access request; held with its payload until `o_mN_gnt`.
- i_mN_addr  in  32  byte address.
- i_mN_wdata  in  32  store data.
- i_mN_strb  in  4  byte strobes.
- i_mN_wren  in  1  1 = store, 0 = load.
- o_mN_gnt  out  1  one-cycle pulse: request accepted and issued to the LSU.
- o_mN_rdata  out  32  load data; valid while `o_mN_rvld` is high.
- o_mN_rvld  out  1  one-cycle load-completion pulse.
- o_mN_err  out  1  high together with `o_mN_rvld` when the load timed out.
- o_lsu_addr  out  32  to the LSU `i_lsu_addr`.
- o_st_data  out  32  to the LSU `i_st_data`.
- o_st_strb  out  4  to the LSU `i_st_strb`.
- o_lsu_wren  out  1  to the LSU `i_lsu_wren`.
- i_ld_data  in  32  from the LSU `o_ld_data`.
- i_data_vld  in  1  from the LSU `o_data_vld`.

## Operation
- FSM states are IDLE, ISSUE and WAIT. Reset state is IDLE.
- **IDLE**
  - Samples requests.
  - If either request is high, select a winner, register its payload onto the LSU outputs, set `o_mN_gnt` (registered) for the winner, and go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE**
  - Lasts exactly one cycle; the LSU outputs carry the winner's payload.
  - Store: the access is complete after this cycle; go to IDLE.
  - Load: go to WAIT and clear the wait counter.
- **Bus outside ISSUE**
  - In IDLE and WAIT the LSU outputs are `o_lsu_addr`=IDLE_ADDR, `o_lsu_wren`=0, `o_st_strb`=0, `o_st_data`=0.
  - This guarantees the LSU never raises `i_data_vld` spuriously and never returns a duplicate response.
- **WAIT**
  - On `i_data_vld`=1: register `i_ld_data` into the owner's `o_mN_rdata`, pulse `o_mN_rvld` for one cycle with `o_mN_err`=0, and go to IDLE.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT−1 with no `i_data_vld`: `o_mN_rdata`=0, pulse `o_mN_rvld` and `o_mN_err`, and go to IDLE.
- **Arbitration**
  - FIXED_PRIO=0: a `last` owner register is kept, with reset value 1. When both masters request, the master not equal to `last` wins. `last` updates on every grant.
  - FIXED_PRIO=1: master 0 always wins.
  - A single requester always wins.
- **Handshake rules**
  - A master holds req and payload stable until it sees gnt.
  - Requests are sampled only in IDLE.
  - A req still high in the first IDLE cycle after completion is treated as a new request.
- **Error cases**
  - `i_data_vld` in IDLE or ISSUE is ignored (stale response). Such a response is never forwarded.
- **Reset**
  - Asynchronous reset returns the FSM to IDLE and zeroes the counter, all gnt, rvld and err outputs, and both rdata outputs. `last`=1 and the LSU outputs take the idle values.
  - A load in flight at reset is dropped with no rvld. Its late `i_data_vld` arrives in IDLE and is ignored.

## Timing
- All outputs are registered.
- **Store**
  - Request in IDLE at cycle 0; gnt and bus payload at cycle 1 (ISSUE); next arbitration at cycle 2.
  - Store throughput is one access per 2 cycles.
- **Load**
  - Gnt and payload at cycle 1; the LSU returns `i_data_vld` at cycle 2 (WAIT); `o_mN_rvld` at cycle 3; next arbitration at cycle 3.
  - Load-to-data latency is 3 cycles.
- **Load timeout**
  - The WAIT state is entered at cycle 2. With RD_TIMEOUT=4, `o_mN_rvld` and `o_mN_err` are asserted at cycle 6.
- **Pulse rules**
  - gnt, rvld and err are single-cycle pulses.
  - At most one master sees gnt, rvld or err in any cycle.

## Test plan
- **Master 0 store:** m0 stores addr 0x2004, data 0xA5A5_1234, strb 4'b0011.
  - `o_m0_gnt` at cycle 1; LSU lines show 0x2004, 0xA5A5_1234, 0x3, wren=1 for exactly one cycle; IDLE_ADDR otherwise.
  - A later load of 0x2004 returns 0x0000_1234 (with RAM previously 0).
- **Master 1 load:** m1 loads 0x7800 with `i_io_sw`=0xDEAD_0001.
  - `o_m1_gnt` at cycle 1; `o_m1_rvld` at cycle 3 with `o_m1_rdata`=0xDEAD_0001, `o_m1_err`=0; m0 outputs stay 0.
- **Round-robin:** both masters issue back-to-back stores, requesting continuously, FIXED_PRIO=0.
  - Grant order from reset is m0, m1, m0, m1, with grants every 2 cycles.
  - With FIXED_PRIO=1, the order is m0, m0, m0 until m0 drops its request.
- **Load timeout:** m0 loads the unmapped address 0x0001_0000.
  - No `i_data_vld` arrives; `o_m0_rvld`=`o_m0_err`=1 at cycle 6 with rdata=0.
  - The FSM is back in IDLE and grants a pending m1 request at the next cycle.
- **Reset in WAIT:** assert `i_rst_n` low asynchronously during WAIT of an m1 load to 0x2000.
  - All outputs go to 0 / IDLE_ADDR immediately.
  - The late `i_data_vld` after release produces no rvld.
  - After release, a tie of both masters grants m0 first.
- **Stale response:** inject `i_data_vld`=1 while in IDLE.
  - No rvld is produced on either master.
